// File: rtl/mem_to_wb_pipe_if.sv
// mem_to_wb_pipe_if -- bundle of the memory-stage, decode-issue and
// register-file writeback signals around the MEM->WB pipeline register.
// master: the surrounding pipeline (drives stage inputs).
// slave : the mem_to_wb_pipe stage itself.
interface mem_to_wb_pipe_if;
    // memory-stage entry and handshake
    logic        mem_valid;
    logic        mem_RegWrite;
    logic        mem_MemtoReg;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_read_data;
    logic        mem_ready;
    // pipeline control
    logic        wb_stall;
    logic        flush;
    // decode issue / hazard lookup
    logic        de_issue;
    logic        de_RegWrite;
    logic [4:0]  de_rd;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    // register-file write port and status
    logic        we3;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [15:0] retire_count;
    logic        sb_error;

    modport master (
        output mem_valid, mem_RegWrite, mem_MemtoReg, mem_rd,
               mem_alu_result, mem_read_data, wb_stall, flush,
               de_issue, de_RegWrite, de_rd, de_rs1, de_rs2,
        input  mem_ready, rs1_busy, rs2_busy, we3, wb_rd, wb_result,
               retire_count, sb_error
    );

    modport slave (
        input  mem_valid, mem_RegWrite, mem_MemtoReg, mem_rd,
               mem_alu_result, mem_read_data, wb_stall, flush,
               de_issue, de_RegWrite, de_rd, de_rs1, de_rs2,
        output mem_ready, rs1_busy, rs2_busy, we3, wb_rd, wb_result,
               retire_count, sb_error
    );
endinterface

// File: rtl/mem_to_wb_pipe.sv
// mem_to_wb_pipe -- single-entry MEM->WB pipeline register with a 32-entry
// busy-bit scoreboard, retire counter and sticky write-after-write error.
// Optional feature: define WB_BYPASS_EN to let rs1_busy/rs2_busy read 0 for
// the register being written back in the current cycle (same-cycle forward).
module mem_to_wb_pipe (
    input  logic              clk,
    input  logic              reset,
    mem_to_wb_pipe_if.slave   bus
);
    // held entry
    logic        r_valid;
    logic        r_regwrite;
    logic [4:0]  r_rd;
    logic [31:0] r_result;
    // scoreboard and status
    logic [31:0] r_busy;
    logic [15:0] r_retire_count;
    logic        r_sb_error;

    logic        w_load;
    logic        w_retire;
    logic        w_we3;
    logic        w_set;
    logic [31:0] w_set_mask;
    logic [31:0] w_clear_mask;
    logic [31:0] w_keep_mask;
    logic [31:0] w_busy_base;
    logic [31:0] w_busy_next;
    logic        w_waw;
    logic        w_rs1_busy;
    logic        w_rs2_busy;

    assign w_load   = bus.mem_valid && !bus.wb_stall && !bus.flush;
    assign w_retire = r_valid && !bus.wb_stall;
    assign w_we3    = r_valid && r_regwrite && (r_rd != 5'd0) && !bus.wb_stall;
    assign w_set    = bus.de_issue && bus.de_RegWrite && (bus.de_rd != 5'd0);

    // Scoreboard next state: retire clear (and flush) first, then the issue
    // set, so a same-cycle set always wins and the WAW check sees the
    // post-clear view of the target bit.
    always_comb begin
        w_set_mask   = '0;
        w_clear_mask = '0;
        w_keep_mask  = '0;
        if (w_set)
            w_set_mask[bus.de_rd] = 1'b1;
        if (w_we3)
            w_clear_mask[r_rd] = 1'b1;
        if (r_valid && r_regwrite && (r_rd != 5'd0))
            w_keep_mask[r_rd] = 1'b1;
        if (bus.flush)
            w_busy_base = r_busy & w_keep_mask & ~w_clear_mask;
        else
            w_busy_base = r_busy & ~w_clear_mask;
        w_busy_next = w_busy_base | w_set_mask;
        w_waw       = w_set && w_busy_base[bus.de_rd];
    end

    // Source-register hazard lookups against the pre-edge busy bits.
    always_comb begin
        w_rs1_busy = (bus.de_rs1 != 5'd0) && r_busy[bus.de_rs1];
        w_rs2_busy = (bus.de_rs2 != 5'd0) && r_busy[bus.de_rs2];
`ifdef WB_BYPASS_EN
        if (w_we3 && (r_rd == bus.de_rs1))
            w_rs1_busy = 1'b0;
        if (w_we3 && (r_rd == bus.de_rs2))
            w_rs2_busy = 1'b0;
`endif
    end

    // Pipeline entry: capture, drain, or hold under stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_result   <= '0;
        end else if (!bus.wb_stall) begin
            if (w_load) begin
                r_valid    <= 1'b1;
                r_regwrite <= bus.mem_RegWrite;
                r_rd       <= bus.mem_rd;
                r_result   <= bus.mem_MemtoReg ? bus.mem_read_data
                                               : bus.mem_alu_result;
            end else begin
                r_valid    <= 1'b0;
            end
        end
    end

    // Scoreboard, retire counter and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy         <= '0;
            r_retire_count <= '0;
            r_sb_error     <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (w_retire)
                r_retire_count <= r_retire_count + 16'd1;
            if (w_waw)
                r_sb_error <= 1'b1;
        end
    end

    assign bus.mem_ready    = !bus.wb_stall;
    assign bus.we3          = w_we3;
    assign bus.wb_rd        = r_rd;
    assign bus.wb_result    = r_result;
    assign bus.rs1_busy     = w_rs1_busy;
    assign bus.rs2_busy     = w_rs2_busy;
    assign bus.retire_count = r_retire_count;
    assign bus.sb_error     = r_sb_error;
endmodule

// File: tb/tb_mem_to_wb_pipe.sv
// tb_mem_to_wb_pipe -- table-driven vectors, directed corner sequences and
// randomized stimulus against a behavioural model of the writeback stage.
module tb_mem_to_wb_pipe;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mem_to_wb_pipe_if bus ();

    mem_to_wb_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        mv, rw, m2r;
        logic [4:0]  rd;
        logic [31:0] alu, rdata;
        logic        stall, fl, iss, irw;
        logic [4:0]  ird, rs1;
        logic        e_ready, e_we3;
        logic [4:0]  e_wbrd;
        logic [31:0] e_res;
        logic        e_rs1b;
    } vec_t;

    vec_t tbl [12];

    // behavioural model state
    bit          m_valid, m_rw;
    bit [4:0]    m_rd;
    bit [31:0]   m_res;
    bit          m_busy [32];
    int unsigned m_cnt;
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic mv, rw, m2r, input logic [4:0] rd,
                       input logic [31:0] alu, rdata,
                       input logic stall, fl, iss, irw,
                       input logic [4:0] ird, rs1, rs2);
        bus.mem_valid      = mv;
        bus.mem_RegWrite   = rw;
        bus.mem_MemtoReg   = m2r;
        bus.mem_rd         = rd;
        bus.mem_alu_result = alu;
        bus.mem_read_data  = rdata;
        bus.wb_stall       = stall;
        bus.flush          = fl;
        bus.de_issue       = iss;
        bus.de_RegWrite    = irw;
        bus.de_rd          = ird;
        bus.de_rs1         = rs1;
        bus.de_rs2         = rs2;
    endtask

    task automatic idle(input logic [4:0] rs1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rs1, 0);
    endtask

    function automatic vec_t mkv(input logic mv, rw, m2r, input logic [4:0] rd,
                                 input logic [31:0] alu, rdata,
                                 input logic stall, fl, iss, irw,
                                 input logic [4:0] ird, rs1,
                                 input logic e_ready, e_we3,
                                 input logic [4:0] e_wbrd,
                                 input logic [31:0] e_res,
                                 input logic e_rs1b);
        vec_t v;
        v.mv = mv; v.rw = rw; v.m2r = m2r; v.rd = rd; v.alu = alu; v.rdata = rdata;
        v.stall = stall; v.fl = fl; v.iss = iss; v.irw = irw; v.ird = ird; v.rs1 = rs1;
        v.e_ready = e_ready; v.e_we3 = e_we3; v.e_wbrd = e_wbrd; v.e_res = e_res;
        v.e_rs1b = e_rs1b;
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_rd = 0; m_res = 0; m_cnt = 0; m_err = 0;
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
    endtask

    // Applies reset for two edges, checks the reset state, then releases it
    // at a falling edge with idle inputs.
    task automatic do_reset();
        idle(0);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we3", bus.we3, 0);
        chk("rst_wb_rd", bus.wb_rd, 0);
        chk("rst_wb_result", bus.wb_result, 0);
        chk("rst_retire_count", bus.retire_count, 0);
        chk("rst_sb_error", bus.sb_error, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One random cycle: drive, compare against model, advance model.
    task automatic rand_cycle();
        bit mv, rw, m2r, st, fl, iss, irw;
        bit [4:0] rd, ird, rs1, rs2;
        bit [31:0] alu, rdata;
        bit e_we3, e_rs1b, e_rs2b;
        mv = ($urandom_range(0, 3) != 0);
        rw = ($urandom_range(0, 3) != 0);
        m2r = 1'($urandom);
        rd = 5'($urandom_range(0, 7));
        alu = $urandom; rdata = $urandom;
        st = ($urandom_range(0, 3) == 0);
        fl = ($urandom_range(0, 15) == 0);
        iss = 1'($urandom); irw = ($urandom_range(0, 3) != 0);
        ird = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
        @(negedge clk);
        drv(mv, rw, m2r, rd, alu, rdata, st, fl, iss, irw, ird, rs1, rs2);
        #1;
        // writeback happens when a held register-writing entry sees no stall
        e_we3  = m_valid && m_rw && (m_rd != 0) && !st;
        e_rs1b = m_busy[rs1] && !(BYP && e_we3 && m_rd == rs1);
        e_rs2b = m_busy[rs2] && !(BYP && e_we3 && m_rd == rs2);
        chk("rnd_mem_ready", bus.mem_ready, !st);
        chk("rnd_we3", bus.we3, e_we3);
        if (e_we3) begin
            chk("rnd_wb_rd", bus.wb_rd, m_rd);
            chk("rnd_wb_result", bus.wb_result, m_res);
        end
        chk("rnd_rs1_busy", bus.rs1_busy, e_rs1b);
        chk("rnd_rs2_busy", bus.rs2_busy, e_rs2b);
        chk("rnd_retire_count", bus.retire_count, m_cnt[15:0]);
        chk("rnd_sb_error", bus.sb_error, m_err);
        // advance model across the edge
        if (m_valid && !st) m_cnt = (m_cnt + 1) % 65536;
        if (e_we3) m_busy[m_rd] = 0;
        if (fl)
            for (int r = 0; r < 32; r++)
                if (!(m_valid && m_rw && r == m_rd)) m_busy[r] = 0;
        if (iss && irw && ird != 0) begin
            if (m_busy[ird]) m_err = 1;
            m_busy[ird] = 1;
        end
        if (!st) begin
            if (mv && !fl) begin
                m_valid = 1; m_rw = rw; m_rd = rd;
                m_res = m2r ? rdata : alu;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        idle(0);

        // mv rw m2r rd alu rdata | st fl iss irw ird rs1 | ready we3 wbrd res rs1b
        tbl[0]  = mkv(0,0,0,0,32'h0,32'h0,           0,0,1,1,5,5,  1,0,0,32'h0,0);
        tbl[1]  = mkv(1,1,0,5,32'h12345678,32'h0,    0,0,0,0,0,5,  1,0,0,32'h0,1);
        tbl[2]  = mkv(0,0,0,0,32'h0,32'h0,           0,0,0,0,0,5,  1,1,5,32'h12345678,!BYP);
        tbl[3]  = mkv(0,0,0,0,32'h0,32'h0,           0,0,0,0,0,5,  1,0,0,32'h0,0);
        tbl[4]  = mkv(1,1,1,7,32'h11111111,32'hDEADBEEF, 0,0,0,0,0,0, 1,0,0,32'h0,0);
        tbl[5]  = mkv(0,0,0,0,32'h0,32'h0,           1,0,0,0,0,0,  0,0,0,32'h0,0);
        tbl[6]  = mkv(0,0,0,0,32'h0,32'h0,           1,0,0,0,0,0,  0,0,0,32'h0,0);
        tbl[7]  = mkv(0,0,0,0,32'h0,32'h0,           1,0,0,0,0,0,  0,0,0,32'h0,0);
        tbl[8]  = mkv(0,0,0,0,32'h0,32'h0,           0,0,0,0,0,0,  1,1,7,32'hDEADBEEF,0);
        tbl[9]  = mkv(0,0,0,0,32'h0,32'h0,           0,0,0,0,0,0,  1,0,0,32'h0,0);
        tbl[10] = mkv(1,1,0,0,32'h0000AAAA,32'h0,    0,0,0,0,0,0,  1,0,0,32'h0,0);
        tbl[11] = mkv(0,0,0,0,32'h0,32'h0,           0,0,0,0,0,0,  1,0,0,32'h0,0);

        do_reset();

        // table: ALU writeback, stalled load, register-0 entry
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drv(tbl[i].mv, tbl[i].rw, tbl[i].m2r, tbl[i].rd, tbl[i].alu, tbl[i].rdata,
                tbl[i].stall, tbl[i].fl, tbl[i].iss, tbl[i].irw, tbl[i].ird, tbl[i].rs1, 0);
            #1;
            chk($sformatf("tbl%0d_mem_ready", i), bus.mem_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_we3", i), bus.we3, tbl[i].e_we3);
            if (tbl[i].e_we3) begin
                chk($sformatf("tbl%0d_wb_rd", i), bus.wb_rd, tbl[i].e_wbrd);
                chk($sformatf("tbl%0d_wb_result", i), bus.wb_result, tbl[i].e_res);
            end
            chk($sformatf("tbl%0d_rs1_busy", i), bus.rs1_busy, tbl[i].e_rs1b);
        end
        @(negedge clk); idle(0); #1;
        chk("tbl_retire_count", bus.retire_count, 3);
        chk("tbl_sb_error", bus.sb_error, 0);

        // same-register set/clear, then a true WAW error
        do_reset();
        @(negedge clk); drv(0,0,0,0,0,0, 0,0,1,1,9,0,0);
        @(negedge clk); drv(1,1,0,9,32'h99,0, 0,0,0,0,0,0,0);
        @(negedge clk); drv(0,0,0,0,0,0, 0,0,1,1,9,0,0); #1;
        chk("ss_we3", bus.we3, 1);
        chk("ss_wb_rd", bus.wb_rd, 9);
        @(negedge clk); idle(9); #1;
        chk("ss_busy9", bus.rs1_busy, 1);
        chk("ss_sb_error", bus.sb_error, 0);
        @(negedge clk); drv(0,0,0,0,0,0, 0,0,1,1,9,9,0);
        @(negedge clk); idle(9); #1;
        chk("waw_sb_error", bus.sb_error, 1);
        chk("waw_busy9", bus.rs1_busy, 1);
        @(negedge clk); idle(9); #1;
        chk("waw_sticky", bus.sb_error, 1);

        // flush: r3 held under stall keeps its bit, r4 cleared, incoming dropped
        do_reset();
        @(negedge clk); drv(0,0,0,0,0,0, 0,0,1,1,3,0,0);
        @(negedge clk); drv(0,0,0,0,0,0, 0,0,1,1,4,0,0);
        @(negedge clk); drv(1,1,0,3,32'h33,0, 0,0,0,0,0,0,0);
        @(negedge clk); drv(1,1,0,12,32'hC0C0,0, 1,1,0,0,0,4,3); #1;
        chk("fl_stall_we3", bus.we3, 0);
        @(negedge clk); drv(1,1,0,12,32'hC0C0,0, 0,1,0,0,0,4,3); #1;
        chk("fl_busy4", bus.rs1_busy, 0);
        chk("fl_busy3", bus.rs2_busy, !BYP);
        chk("fl_we3", bus.we3, 1);
        chk("fl_wb_rd", bus.wb_rd, 3);
        chk("fl_wb_result", bus.wb_result, 32'h33);
        @(negedge clk); drv(0,0,0,0,0,0, 0,0,0,0,0,12,3); #1;
        chk("fl_dropped_we3", bus.we3, 0);
        chk("fl_busy3_clear", bus.rs2_busy, 0);
        chk("fl_retire_count", bus.retire_count, 1);

        // reset asserted mid-stall discards the held entry
        do_reset();
        @(negedge clk); drv(1,1,0,6,32'h66,0, 0,0,1,1,6,6,0);
        @(negedge clk); drv(0,0,0,0,0,0, 1,0,0,0,0,6,0); #1;
        chk("rs_stall_we3", bus.we3, 0);
        @(negedge clk); #1;
        reset = 1'b0; #1;
        chk("rs_async_we3", bus.we3, 0);
        chk("rs_async_wb_rd", bus.wb_rd, 0);
        chk("rs_async_wb_result", bus.wb_result, 0);
        chk("rs_async_busy6", bus.rs1_busy, 0);
        @(negedge clk); reset = 1'b1; drv(1,1,0,8,32'h88,0, 0,0,0,0,0,0,0); #1;
        chk("rs_after_we3", bus.we3, 0);
        @(negedge clk); idle(0); #1;
        chk("rs_resume_we3", bus.we3, 1);
        chk("rs_resume_wb_rd", bus.wb_rd, 8);
        chk("rs_resume_count", bus.retire_count, 0);

        // retire counter wrap
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            drv(1,0,0,1,i,0, 0,0,0,0,0,0,0);
        end
        @(negedge clk); idle(0); #1;
        chk("wrap_ffff", bus.retire_count, 16'hFFFF);
        @(negedge clk); #1;
        chk("wrap_zero", bus.retire_count, 0);

        // randomized against the model
        do_reset();
        for (int i = 0; i < 3000; i++) rand_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_to_wb_pipe.md
MEM_TO_WB_PIPE -- requirements
Module: mem_to_wb_pipe

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with the port list below (clock and reset first).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- mem_valid  in  1  memory stage holds an instruction.
- mem_RegWrite, mem_MemtoReg  in  1 each  control bits carried from decode.
- mem_rd  in  5  destination register.
- mem_alu_result, mem_read_data  in  32 each  ALU result and load data.
- mem_ready  out  1  stage accepts the memory-stage entry this cycle.
- wb_stall  in  1  register-file write port unavailable.
- flush  in  1  squash younger pipeline state.
- de_issue, de_RegWrite  in  1 each  decode issues an instruction.
- de_rd  in  5  destination register of the issuing instruction.
- de_rs1, de_rs2  in  5 each  decode source registers.
- rs1_busy, rs2_busy  out  1 each  source register has a pending write.
- we3  out  1  register-file write enable.
- wb_rd  out  5  register-file write address.
- wb_result  out  32  register-file write data.
- retire_count  out  16  count of retired instructions.
- sb_error  out  1  sticky write-after-write protocol error.

Function
REQ-002 The stage SHALL hold one entry: valid, RegWrite, rd, and result, where result = MemtoReg ? mem_read_data : mem_alu_result, selected at capture.
REQ-003 mem_ready SHALL equal !wb_stall.
REQ-004 The entry SHALL be loaded when mem_valid && mem_ready && !flush. When !wb_stall and no load occurs, the entry SHALL become invalid.
REQ-005 When wb_stall=1, the entry SHALL be held unchanged.
REQ-006 we3 SHALL be combinational: entry valid && RegWrite && rd!=0 && !wb_stall. wb_rd and wb_result SHALL be driven from the entry.
REQ-007 Latency SHALL be exactly 1 cycle from capture edge to we3 high when no stall occurs. A stall delays we3 by the number of stall cycles.
REQ-008 Register 0 SHALL never be written and SHALL never report busy.
REQ-009 The scoreboard SHALL be 32 busy bits:
- set on de_issue && de_RegWrite && de_rd!=0;
- cleared for wb_rd when we3=1.
REQ-010 If a set and a clear hit the same register in the same cycle, the set SHALL win.
REQ-011 rs1_busy and rs2_busy SHALL be combinational lookups of the busy bits, evaluated before the edge.
REQ-012 If de_issue sets a register that is already busy and not being cleared that cycle, sb_error SHALL set and stay set until reset. The busy bit SHALL remain 1.
REQ-013 On flush:
- all busy bits SHALL clear, except the bit for a valid, RegWrite entry currently held in the stage;
- the incoming memory-stage entry SHALL be dropped;
- the held entry SHALL retire normally.
REQ-014 Flush and issue in the same cycle: flush SHALL apply first, then the issue set.
REQ-015 retire_count SHALL increment by 1 on every cycle in which a valid entry leaves the stage with !wb_stall (any RegWrite value). It SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-016 While reset=0, the following SHALL hold:
- entry valid=0, all busy bits 0, retire_count=0, sb_error=0;
- we3=0, wb_rd=0, wb_result=0.
REQ-017 Reset asserted mid-stall SHALL discard the held entry with no write. Normal operation SHALL resume on the first edge after reset deasserts.

Configuration
REQ-018 With macro WB_BYPASS_EN defined, rs1_busy/rs2_busy SHALL read 0 for a register whose write has we3=1 in the current cycle, allowing same-cycle forwarding. Without the macro, such registers SHALL report busy until the edge that clears the bit.

Verification
REQ-019 ALU writeback: issue rd=5, then capture alu=0x1234_5678 with MemtoReg=0 → next cycle we3=1, wb_rd=5, wb_result=0x12345678; busy[5] clears; retire_count=1.
REQ-020 Load with stall: capture MemtoReg=1, read_data=0xDEADBEEF, rd=7, then hold wb_stall=1 for 3 cycles → we3=0 and mem_ready=0 for 3 cycles; then one we3=1 pulse with 0xDEADBEEF.
REQ-021 Register 0: capture rd=0 with RegWrite=1 → we3 stays 0, retire_count still increments, and rs1_busy stays 0 for de_rs1=0.
REQ-022 Same-register set/clear: de_issue rd=9 in the same cycle that a retiring entry writes r9 → busy[9]=1 after the edge; sb_error stays 0.
REQ-023 Flush: busy r3, r4; entry rd=3 held; flush=1 → busy[4]=0, busy[3]=1; next write clears r3; an incoming mem_valid entry that cycle is never written.
REQ-024 Wrap and bypass: preload 0xFFFF retires, retire one more → retire_count=0x0000. With WB_BYPASS_EN, de_rs1=5 during the we3 cycle for r5 → rs1_busy=0; without it → rs1_busy=1.
